// File: rtl/inst_fetch.sv
// Fetch stage: request/ack instruction read, hold until decode consumes, pulse pc_wre.
// Optional misaligned-PC trap enabled by defining FETCH_ALIGN_CHECK_EN.
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              consume,
  output logic              pc_wre,
  output logic [CNT_W-1:0]  fetch_count,
  output logic              align_fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [1:0]        state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic              wre_q, wre_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fetch_go;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic fault_hit;

  // A sticky fault blocks all fetching until flushed.
  assign fetch_go  = fetch_en && !wre_q && !fault_q
                     && (pc[1:0] == 2'b00);
  assign fault_hit = fetch_en && !wre_q && !fault_q
                     && (pc[1:0] != 2'b00);
`else
  // pc is stale during the pc_wre cycle, so never start then.
  assign fetch_go = fetch_en && !wre_q;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    wre_d   = 1'b0;
    cnt_d   = cnt_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    if (flush) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
      valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fetch_go) begin
            addr_d  = pc & ALIGN_MASK;
            req_d   = 1'b1;
            state_d = S_REQ;
          end
`ifdef FETCH_ALIGN_CHECK_EN
          else if (fault_hit) begin
            fault_d = 1'b1;
          end
`endif
        end
        S_REQ: begin
          if (imem_ack) begin
            instr_d = imem_rdata;
            ipc_d   = addr_q;
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (consume) begin
            valid_d = 1'b0;
            wre_d   = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      wre_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      wre_q   <= wre_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (Reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
  assign align_fault = fault_q;
`else
  assign align_fault = 1'b0;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign pc_wre      = wre_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: output-level reference model plus directed scenarios.
// Counter width is reduced so the wrap case fits in a short run.
module tb_inst_fetch;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic [AW-1:0] pc = '0;
  logic          fetch_en = 1'b0;
  logic          flush = 1'b0;
  logic          consume = 1'b0;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          pc_wre;
  logic [CW-1:0] fetch_count;
  logic          align_fault;

  inst_fetch #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .Reset(Reset), .pc(pc), .fetch_en(fetch_en),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid),
    .consume(consume), .pc_wre(pc_wre), .fetch_count(fetch_count),
    .align_fault(align_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // memory responder
  int mem_wait = 0;
  logic [DW-1:0] mem_data = '0;
  int wcnt = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (imem_req && !Reset) begin
      if (wcnt == mem_wait) begin
        imem_ack = 1'b1;
        imem_rdata = mem_data;
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wcnt = 0;
    end
  end

  // reference model, tracked directly in terms of visible outputs
  logic          m_req = 0, m_valid = 0, m_wre = 0, m_fault = 0;
  logic [AW-1:0] m_addr = '0, m_ipc = '0;
  logic [DW-1:0] m_instr = '0;
  logic [CW-1:0] m_cnt = '0;

  always @(posedge clk) begin
    if (Reset) begin
      m_req <= 0; m_valid <= 0; m_wre <= 0; m_fault <= 0;
      m_addr <= '0; m_ipc <= '0; m_instr <= '0; m_cnt <= '0;
    end else begin
      m_wre <= 1'b0;
      if (flush) begin
        m_req <= 0; m_valid <= 0; m_fault <= 0;
      end else if (m_valid) begin
        if (consume) begin
          m_valid <= 0; m_wre <= 1; m_cnt <= m_cnt + 1'b1;
        end
      end else if (m_req) begin
        if (imem_ack) begin
          m_instr <= imem_rdata; m_ipc <= m_addr;
          m_valid <= 1; m_req <= 0;
        end
      end else if (fetch_en && !m_wre && !m_fault) begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (pc[1:0] != 2'b00) m_fault <= 1;
        else begin m_req <= 1; m_addr <= pc; end
`else
        m_req <= 1; m_addr <= {pc[AW-1:2], 2'b00};
`endif
      end
    end
  end

  // per-cycle comparison and output activity monitors
  int req_cyc = 0, wre_pulses = 0, unstable = 0, ncyc = 0;
  int wre_t_prev = 0, wre_t_last = 0;
  logic          prev_req = 0;
  logic [AW-1:0] prev_addr = '0;
  initial forever begin
    @(negedge clk);
    ncyc++;
    if (chk_en) begin
      total++;
      if (imem_req !== m_req || imem_addr !== m_addr ||
          instr !== m_instr || instr_pc !== m_ipc ||
          instr_valid !== m_valid || pc_wre !== m_wre ||
          fetch_count !== m_cnt || align_fault !== m_fault) begin
        bad++;
        $display("FAIL model t=%0t got req=%0b addr=%h ins=%h ipc=%h v=%0b wre=%0b cnt=%0d af=%0b want req=%0b addr=%h ins=%h ipc=%h v=%0b wre=%0b cnt=%0d af=%0b",
          $time, imem_req, imem_addr, instr, instr_pc, instr_valid,
          pc_wre, fetch_count, align_fault, m_req, m_addr, m_instr,
          m_ipc, m_valid, m_wre, m_cnt, m_fault);
      end
      if (imem_req) req_cyc++;
      if (pc_wre) begin
        wre_pulses++;
        wre_t_prev = wre_t_last;
        wre_t_last = ncyc;
      end
      if (imem_req && prev_req && imem_addr !== prev_addr) unstable++;
      prev_req = imem_req;
      prev_addr = imem_addr;
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_instr"}, instr, 0);
    check({tag, "_ipc"}, instr_pc, 0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_wre"}, pc_wre, 0);
    check({tag, "_cnt"}, fetch_count, 0);
    check({tag, "_fault"}, align_fault, 0);
  endtask

  task automatic wait_req(input string nm);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc;
      if (imem_req) ok = 1;
    end
    check({nm, "_req_timeout"}, ok, 1);
  endtask

  task automatic do_fetch(input string nm, input logic [AW-1:0] a,
                          input int w, input logic [DW-1:0] d,
                          input int hold);
    bit ok = 0;
    int rb = req_cyc;
    int wb = wre_pulses;
    pc = a; mem_wait = w; mem_data = d;
    fetch_en = 1; consume = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      cyc;
      if (instr_valid) ok = 1;
    end
    fetch_en = 0;
    check({nm, "_valid_timeout"}, ok, 1);
    check({nm, "_instr"}, instr, d);
    check({nm, "_instr_pc"}, instr_pc, a & ~32'h3);
    check({nm, "_req_cycles"}, req_cyc - rb, w + 1);
    for (int i = 0; i < hold; i++) begin
      cyc;
      check({nm, "_held"}, {instr_valid, pc_wre}, 2'b10);
    end
    consume = 1;
    cyc;
    consume = 0;
    check({nm, "_wre_hi"}, pc_wre, 1);
    cyc;
    check({nm, "_wre_lo"}, pc_wre, 0);
    cyc;
    check({nm, "_wre_pulses"}, wre_pulses - wb, 1);
  endtask

  initial begin
    int wb;
    bit ok;
    cyc; cyc;
    reset_vals("reset");
    chk_en = 1;
    Reset = 0;
    cyc;

    do_fetch("t1", 32'h0, 0, 32'h2008_0005, 0);
    check("t1_count", fetch_count, 1);

    do_fetch("t2", 32'h10, 5, 32'h1234_5678, 0);
    check("t2_addr_stable", unstable, 0);
    check("t2_count", fetch_count, 2);

    do_fetch("t3", 32'h14, 1, 32'hA5A5_0F0F, 10);
    check("t3_count", fetch_count, 3);

    // flush coincides with the ack cycle
    wb = wre_pulses;
    pc = 32'h20; mem_wait = 2; mem_data = 32'hDEAD_BEEF;
    fetch_en = 1;
    wait_req("fl");
    fetch_en = 0;
    cyc; cyc;
    flush = 1;
    cyc;
    flush = 0;
    check("fl_valid", instr_valid, 0);
    check("fl_req", imem_req, 0);
    cyc; cyc;
    check("fl_valid2", instr_valid, 0);
    check("fl_wre", wre_pulses - wb, 0);
    check("fl_count", fetch_count, 3);

    // back-to-back, zero-wait, consume held
    wb = wre_pulses;
    pc = 32'h40; mem_wait = 0; mem_data = 32'h0000_0013;
    fetch_en = 1; consume = 1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc;
      if (wre_pulses - wb >= 3) ok = 1;
    end
    fetch_en = 0; consume = 0;
    check("b2b_timeout", ok, 1);
    check("b2b_period", wre_t_last - wre_t_prev, 4);
    flush = 1;
    cyc;
    flush = 0;
    cyc;
    check("b2b_count", fetch_count, 6);

    for (int i = 0; i < 9; i++)
      do_fetch("wr", 32'h100 + i * 4, i % 3, 32'h100 + i, 0);
    check("wrap_pre", fetch_count, 15);
    do_fetch("wr_last", 32'h200, 0, 32'hCAFE_F00D, 0);
    check("wrap_zero", fetch_count, 0);

    // Reset lands on the ack cycle of an outstanding request
    pc = 32'h80; mem_wait = 2; mem_data = 32'h1111_2222;
    fetch_en = 1;
    wait_req("rs");
    fetch_en = 0;
    cyc; cyc;
    Reset = 1;
    cyc;
    reset_vals("midreq");
    Reset = 0;
    cyc; cyc;
    check("midreq_after", {imem_req, instr_valid}, 2'b00);

    pc = 32'h6; mem_wait = 0; mem_data = 32'h0040_0093;
    fetch_en = 1;
`ifdef FETCH_ALIGN_CHECK_EN
    cyc; cyc; cyc;
    check("al_req", imem_req, 0);
    check("al_fault", align_fault, 1);
    cyc;
    check("al_sticky", align_fault, 1);
    fetch_en = 0;
    flush = 1;
    cyc;
    flush = 0;
    check("al_cleared", align_fault, 0);
`else
    wait_req("al");
    fetch_en = 0;
    check("al_addr", imem_addr, 32'h4);
    check("al_fault", align_fault, 0);
    cyc;
    consume = 1;
    cyc;
    consume = 0;
    cyc;
`endif
    cyc; cyc;
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage directly downstream of the program counter register.
- Takes the current `pc` and issues a request/acknowledge read to instruction memory, which has variable latency.
- Holds the returned word in an instruction register until decode accepts it, then pulses `pc_wre` so the PC advances exactly once per delivered instruction.
- Supports flush on redirect and keeps a delivered-instruction counter.

Parameters:
- ADDR_W, 32, width of the PC and memory address.
- DATA_W, 32, width of the instruction word.
- CNT_W, 16, width of the delivered-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- pc  in  ADDR_W  current PC value from the PC register.
- fetch_en  in  1  permits a new fetch to start.
- flush  in  1  discards any in-flight or held instruction.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  read address; stable while imem_req=1.
- imem_ack  in  1  memory has data this cycle.
- imem_rdata  in  DATA_W  read data; valid when imem_ack=1.
- instr  out  DATA_W  held instruction.
- instr_pc  out  ADDR_W  address the held instruction came from.
- instr_valid  out  1  instr/instr_pc valid for decode.
- consume  in  1  decode accepts the held instruction.
- pc_wre  out  1  one-cycle write enable to the PC register.
- fetch_count  out  CNT_W  instructions delivered (consumed), wraps modulo 2^CNT_W.
- align_fault  out  1  misaligned-PC flag (see Optional Feature).

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high):
  - state=IDLE.
  - imem_req=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0, pc_wre=0, fetch_count=0, align_fault=0.
  - Reset overrides every other input, including mid-request; an ack arriving in the reset cycle is ignored.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - If fetch_en=1 and flush=0: imem_addr<=pc, imem_req<=1, go to REQ. The request is visible the cycle after pc is sampled.
  - Otherwise stay in IDLE.
- REQ:
  - imem_req and imem_addr are held constant until imem_ack is sampled 1. Any number of wait cycles is allowed, including zero (ack in the first REQ cycle).
  - On ack: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, imem_req<=0, go to HOLD.
- HOLD:
  - instr_valid stays 1 and instr/instr_pc stay stable until consume=1.
  - On consume: instr_valid<=0, pc_wre<=1 for exactly one cycle, fetch_count<=fetch_count+1, go to IDLE.
  - consume is ignored in IDLE and REQ.
- pc_wre is 0 in every cycle except the cycle after a consume.
  - The PC updates on the edge at the end of the pc_wre cycle.
  - IDLE does not start a new fetch in the cycle pc_wre=1, because pc is still old. The earliest new request is therefore 2 cycles after consume.
- Flush, in any state:
  - imem_req<=0, instr_valid<=0, go to IDLE.
  - No pc_wre pulse and no count increment.
  - Flush has priority over consume and over imem_ack; the data from a same-cycle ack is discarded.
- Back-to-back minimum throughput (zero-wait memory, consume held 1): one instruction every 4 cycles.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - In IDLE with fetch_en=1 and pc[1:0]!=0: no request is issued, align_fault<=1, state stays IDLE.
  - align_fault is sticky until Reset or flush.
  - While align_fault=1, no fetch starts.
- Not defined:
  - pc[1:0] is ignored; imem_addr is taken as {pc[ADDR_W-1:2],2'b00}.
  - align_fault is tied to 0.

Test Plan:
- Reset then pc=0x00000000, fetch_en=1, memory acks after 0 waits with rdata=0x20080005, consume=1 -> imem_req high 1 cycle at addr 0; instr=0x20080005, instr_pc=0; pc_wre single pulse; fetch_count=1.
- pc=0x00000010, ack delayed 5 cycles -> imem_req/imem_addr=0x10 stable for all 6 REQ cycles; instr_valid rises the cycle after ack.
- Instruction held, consume=0 for 10 cycles, then 1 -> instr_valid=1 throughout, pc_wre=0 until the consume; exactly one pc_wre pulse.
- flush asserted in the same cycle as imem_ack=1 (rdata=0xDEADBEEF) -> instr_valid stays 0, state=IDLE, no pc_wre, fetch_count unchanged.
- fetch_count=0xFFFF plus one more consume -> fetch_count=0x0000. Separately, Reset asserted mid-REQ -> imem_req=0 next cycle and all outputs at reset values.
- FETCH_ALIGN_CHECK_EN defined, pc=0x00000006, fetch_en=1 -> no imem_req, align_fault=1 until flush. Macro undefined, same pc -> imem_addr=0x00000004, align_fault=0.
